// File: rtl/wiper_motor.sv
// rtl/wiper_motor.sv - wiper arm sweep motor: three-state sweep FSM with speed-selected step divider
module wiper_motor #(
  parameter int POS_MAX  = 7,
  parameter int LOW_DIV  = 4,
  parameter int HIGH_DIV = 2
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic [1:0] speed,
  output logic [3:0] arm_pos,
  output logic       motor_on,
  output logic       motor_dir,
  output logic       parked,
  output logic [7:0] sweep_count
);

  localparam int CW = 8;

  typedef enum logic [1:0] {PARKED, SWEEP_OUT, SWEEP_BACK} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pos_q, pos_d;
  logic [7:0]    sweeps_q, sweeps_d;
  logic [CW-1:0] div_m1;
  logic          step;

  // A ">=" compare lets a mid-count switch to a shorter divisor step at once.
  assign div_m1 = speed[1] ? CW'(HIGH_DIV - 1) : CW'(LOW_DIV - 1);
  assign step   = (cnt_q >= div_m1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    sweeps_d = sweeps_q;
    case (state_q)
      PARKED: begin
        cnt_d = '0;
        if (speed != 2'd0) state_d = SWEEP_OUT;
      end
      SWEEP_OUT, SWEEP_BACK: begin
        if (!step) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (state_q == SWEEP_OUT && speed != 2'd0) begin
            pos_d = pos_q + 4'd1;
            if (pos_d == 4'(POS_MAX)) state_d = SWEEP_BACK;
          end else if (state_q == SWEEP_OUT && pos_q == 4'd0) begin
            state_d = PARKED;
          end else begin
            // Early return from 1 lands at rest here too, so it counts as a completed return.
            pos_d = pos_q - 4'd1;
            if (pos_d == 4'd0) begin
              sweeps_d = sweeps_q + 8'd1;
              state_d  = (speed != 2'd0) ? SWEEP_OUT : PARKED;
            end else begin
              state_d = SWEEP_BACK;
            end
          end
        end
      end
      default: state_d = PARKED;
    endcase
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= PARKED;
      cnt_q    <= '0;
      pos_q    <= '0;
      sweeps_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      sweeps_q <= sweeps_d;
    end
  end

  assign arm_pos     = pos_q;
  assign sweep_count = sweeps_q;
  assign motor_on    = (state_q != PARKED);
  assign motor_dir   = (state_q == SWEEP_OUT);
  assign parked      = (state_q == PARKED);

endmodule

// File: tb/tb_wiper_motor.sv
// tb/tb_wiper_motor.sv - self-checking bench for wiper_motor against a behavioural sweep model
module tb_wiper_motor;

  localparam int POS_MAX  = 7;
  localparam int LOW_DIV  = 4;
  localparam int HIGH_DIV = 2;

  logic       clk_2 = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [3:0] arm_pos;
  logic       motor_on, motor_dir, parked;
  logic [7:0] sweep_count;

  int errors = 0;
  int checks = 0;

  wiper_motor #(.POS_MAX(POS_MAX), .LOW_DIV(LOW_DIV), .HIGH_DIV(HIGH_DIV)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .speed(speed), .arm_pos(arm_pos),
    .motor_on(motor_on), .motor_dir(motor_dir), .parked(parked), .sweep_count(sweep_count)
  );

  always #5 clk_2 = ~clk_2;

  // Model: mode 0 = resting, 1 = moving outward, 2 = returning; m_wait = cycles spent waiting for a step.
  int m_mode, m_pos, m_sweeps, m_wait;

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_sweeps = 0; m_wait = 0;
  endfunction

  function automatic void model_edge(int spd);
    int div;
    div = (spd >= 2) ? HIGH_DIV : LOW_DIV;
    if (m_mode == 0) begin
      m_wait = 0;
      if (spd != 0) m_mode = 1;
    end else if (m_wait < div - 1) begin
      m_wait++;
    end else begin
      m_wait = 0;
      if (m_mode == 1 && spd != 0) begin
        m_pos++;
        if (m_pos == POS_MAX) m_mode = 2;
      end else if (m_mode == 1 && m_pos == 0) begin
        m_mode = 0;
      end else begin
        m_pos--;
        if (m_pos == 0) begin
          m_sweeps = (m_sweeps + 1) % 256;
          m_mode = (spd != 0) ? 1 : 0;
        end else begin
          m_mode = 2;
        end
      end
    end
  endfunction

  function automatic logic [14:0] model_outs();
    return {4'(m_pos), m_mode != 0, m_mode == 1, m_mode == 0, 8'(m_sweeps)};
  endfunction

  // Triangular arm position k cycles after entering the outward sweep at a fixed divisor.
  function automatic int tri_pos(int k, int div);
    int s;
    s = (k / div) % (2 * POS_MAX);
    return (s <= POS_MAX) ? s : 2 * POS_MAX - s;
  endfunction

  task automatic tick();
    @(posedge clk_2);
    if (reset_n) model_edge(int'(speed));
    @(negedge clk_2);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    speed = 2'd0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_step(output int n);
    logic [3:0] prev;
    prev = arm_pos;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (arm_pos != prev) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    speed = 2'd2;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({arm_pos, parked, motor_on, sweep_count} !== {4'd0, 1'b1, 1'b0, 8'd0}) begin
        errors++;
        $display("FAIL reset_hold: pos=%0d parked=%0b on=%0b cnt=%0d required 0/1/0/0",
                 arm_pos, parked, motor_on, sweep_count);
      end
    end
  endtask

  task automatic test_low_sweep();
    reset_n = 1'b1;
    speed = 2'd1;
    tick();
    checks++;
    if ({motor_on, motor_dir, arm_pos} !== {1'b1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL low_start: on=%0b dir=%0b pos=%0d required 1/1/0", motor_on, motor_dir, arm_pos);
    end
    for (int k = 1; k <= 2 * POS_MAX * LOW_DIV; k++) begin
      tick();
      checks++;
      if (arm_pos !== 4'(tri_pos(k, LOW_DIV))) begin
        errors++;
        $display("FAIL low_pos k=%0d: pos=%0d required %0d", k, arm_pos, tri_pos(k, LOW_DIV));
      end
      if (k == POS_MAX * LOW_DIV) begin
        checks++;
        if ({arm_pos, motor_dir} !== {4'(POS_MAX), 1'b0}) begin
          errors++;
          $display("FAIL low_outer: pos=%0d dir=%0b required %0d/0", arm_pos, motor_dir, POS_MAX);
        end
      end
    end
    checks++;
    if ({arm_pos, sweep_count, motor_on, motor_dir} !== {4'd0, 8'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL low_return: pos=%0d cnt=%0d on=%0b dir=%0b required 0/1/1/1",
               arm_pos, sweep_count, motor_on, motor_dir);
    end
  endtask

  task automatic test_high_and_3();
    logic [11:0] trace [0:56];
    do_reset();
    speed = 2'd2;
    for (int k = 0; k <= 2 * 2 * POS_MAX * HIGH_DIV; k++) begin
      tick();
      trace[k] = {arm_pos, sweep_count};
      if (k > 0) begin
        checks++;
        if ({arm_pos, sweep_count} !== {4'(tri_pos(k, HIGH_DIV)), 8'(k / (2 * POS_MAX * HIGH_DIV))}) begin
          errors++;
          $display("FAIL high_trace k=%0d: pos=%0d cnt=%0d required %0d/%0d", k, arm_pos, sweep_count,
                   tri_pos(k, HIGH_DIV), k / (2 * POS_MAX * HIGH_DIV));
        end
      end
    end
    do_reset();
    speed = 2'd3;
    for (int k = 0; k <= 2 * 2 * POS_MAX * HIGH_DIV; k++) begin
      tick();
      checks++;
      if ({arm_pos, sweep_count} !== trace[k]) begin
        errors++;
        $display("FAIL speed3_trace k=%0d: got %h required %h", k, {arm_pos, sweep_count}, trace[k]);
      end
    end
  endtask

  task automatic test_early_return();
    int n;
    do_reset();
    speed = 2'd1;
    for (int i = 0; i < 200 && !(m_mode == 1 && m_pos == 3); i++) tick();
    checks++;
    if ({arm_pos, motor_dir} !== {4'd3, 1'b1}) begin
      errors++;
      $display("FAIL early_setup: pos=%0d dir=%0b required 3/1", arm_pos, motor_dir);
    end
    speed = 2'd0;
    wait_step(n);
    checks++;
    if (n !== LOW_DIV || arm_pos !== 4'd2 || motor_dir !== 1'b0) begin
      errors++;
      $display("FAIL early_first: gap=%0d pos=%0d dir=%0b required %0d/2/0", n, arm_pos, motor_dir, LOW_DIV);
    end
    wait_step(n);
    checks++;
    if (n !== LOW_DIV || arm_pos !== 4'd1) begin
      errors++;
      $display("FAIL early_second: gap=%0d pos=%0d required %0d/1", n, arm_pos, LOW_DIV);
    end
    wait_step(n);
    checks++;
    if ({arm_pos, parked, motor_on, sweep_count} !== {4'd0, 1'b1, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL early_park: pos=%0d parked=%0b on=%0b cnt=%0d required 0/1/0/1",
               arm_pos, parked, motor_on, sweep_count);
    end
  endtask

  task automatic test_back_speed_change();
    int n;
    do_reset();
    speed = 2'd2;
    for (int i = 0; i < 200 && !(m_mode == 2 && m_wait == 1); i++) tick();
    checks++;
    if (motor_dir !== 1'b0 || !motor_on) begin
      errors++;
      $display("FAIL back_setup: dir=%0b on=%0b required 0/1", motor_dir, motor_on);
    end
    speed = 2'd1;
    wait_step(n);
    checks++;
    if (n !== LOW_DIV - 1) begin
      errors++;
      $display("FAIL back_first_step: gap=%0d required %0d", n, LOW_DIV - 1);
    end
    for (int j = 0; j < 2; j++) begin
      wait_step(n);
      checks++;
      if (n !== LOW_DIV) begin
        errors++;
        $display("FAIL back_next_step %0d: gap=%0d required %0d", j, n, LOW_DIV);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    speed = 2'd2;
    for (int i = 0; i < 8000 && m_sweeps != 255; i++) tick();
    for (int i = 0; i < 200 && !(m_mode == 1 && m_pos == 5); i++) tick();
    checks++;
    if ({arm_pos, motor_dir, sweep_count} !== {4'd5, 1'b1, 8'd255}) begin
      errors++;
      $display("FAIL mid_setup: pos=%0d dir=%0b cnt=%0d required 5/1/255", arm_pos, motor_dir, sweep_count);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({arm_pos, sweep_count, parked, motor_on, motor_dir} !== {4'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: pos=%0d cnt=%0d parked=%0b on=%0b dir=%0b required 0/0/1/0/0",
               arm_pos, sweep_count, parked, motor_on, motor_dir);
    end
    @(negedge clk_2);
    reset_n = 1'b1;
    speed = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (parked !== 1'b1 || motor_on !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle: parked=%0b on=%0b required 1/0", parked, motor_on);
      end
    end
    speed = 2'd1;
    tick();
    checks++;
    if ({motor_on, motor_dir, arm_pos} !== {1'b1, 1'b1, 4'd0}) begin
      errors++;
      $display("FAIL post_reset_start: on=%0b dir=%0b pos=%0d required 1/1/0", motor_on, motor_dir, arm_pos);
    end
  endtask

  task automatic test_random();
    int hold;
    do_reset();
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        speed = 2'($urandom_range(0, 3));
        hold = $urandom_range(1, 40);
      end
      hold--;
      tick();
      checks++;
      if ({arm_pos, motor_on, motor_dir, parked, sweep_count} !== model_outs()) begin
        errors++;
        $display("FAIL random c=%0d: got pos=%0d on=%0b dir=%0b parked=%0b cnt=%0d required %h",
                 c, arm_pos, motor_on, motor_dir, parked, sweep_count, model_outs());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_low_sweep();
    test_high_and_3();
    test_early_return();
    test_back_speed_change();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
